// File: rtl/phase_sample_fifo.sv
// phase_sample_fifo: synchronised spin-vs-reference mismatch, per-spin saturating phase
// counters and a decimated raw-sample FIFO. Optional macro: SAMPLE_FIFO_OVERWRITE_EN.
`ifndef PHASE_ADDR_BASE
`define PHASE_ADDR_BASE 32'h0000_1000
`endif

module phase_sample_fifo #(
  parameter int N           = 3,
  parameter int CW          = 32,
  parameter int SYNC_STAGES = 3,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        stop,
  input  logic [CW-1:0]               counter_max,
  input  logic [CW-1:0]               counter_cutoff,
  input  logic [$clog2(N)-1:0]        ref_idx,
  input  logic [15:0]                 decim,
  input  logic [N-1:0]                outputs,
  input  logic [31:0]                 rd_addr,
  output logic [CW-1:0]               phase,
  input  logic                        fifo_rd_en,
  output logic [N-1:0]                fifo_rd_data,
  output logic                        fifo_empty,
  output logic                        fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        fifo_ovf,
  output logic                        running
);

  localparam int RW = $clog2(N);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   OCC_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   OCC_FULL  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  state_e           state_r, state_next_s;
  logic [RW-1:0]    ref_q_r;
  logic [N-1:0]     sync_r [SYNC_STAGES];
  logic [N-1:0]     mismatch_s, sync_mm_s;
  logic             ref_bit_s;
  logic [CW-1:0]    cnt_r [N];
  logic [CW-1:0]    arm_val_s;
  logic [15:0]      dcnt_r;
  logic [N-1:0]     mem_r [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [AW:0]      count_r;
  logic             ovf_r;
  logic             upd_s, push_s, pop_s, wr_en_s, rd_adv_s, ovf_set_s;
  logic [31:0]      idx_s;

  function automatic logic [CW-1:0] step_cnt(input logic [CW-1:0] c, input logic mm,
                                             input logic [CW-1:0] mx);
    logic [CW-1:0] r;
    if (mm) r = (c == {CW{1'b0}}) ? c : c - CNT_ONE;
    else    r = (c >= mx) ? c : c + CNT_ONE;
    return r;
  endfunction

  // Reference bit pick; an out-of-range latch reads as 0 rather than X
  always_comb begin
    ref_bit_s = 1'b0;
    for (int i = 0; i < N; i++) ref_bit_s = ref_bit_s | (outputs[i] & (ref_q_r == RW'(i)));
    mismatch_s = outputs ^ {N{ref_bit_s}};
  end

  assign sync_mm_s = sync_r[SYNC_STAGES-1];

  // Mismatch synchroniser chain
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_r[s] <= {N{1'b0}};
    end else begin
      sync_r[0] <= mismatch_s;
      for (int s = 1; s < SYNC_STAGES; s++) sync_r[s] <= sync_r[s-1];
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_next_s;
  end

  // FSM next state; start outranks stop in either state
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: if (start) state_next_s = ST_RUN; else state_next_s = ST_IDLE;
      ST_RUN: begin
        if (start)     state_next_s = ST_RUN;
        else if (stop) state_next_s = ST_IDLE;
        else           state_next_s = ST_RUN;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  assign running   = (state_r == ST_RUN);
  assign upd_s     = running && !start && !stop;
  assign push_s    = upd_s && (dcnt_r == decim);
  assign arm_val_s = (counter_cutoff < counter_max) ? counter_cutoff : counter_max;

  // Phase counters, reference latch and decimation counter
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) cnt_r[i] <= {CW{1'b0}};
      ref_q_r <= {RW{1'b0}};
      dcnt_r  <= 16'd0;
    end else if (start) begin
      for (int i = 0; i < N; i++) cnt_r[i] <= arm_val_s;
      ref_q_r <= ref_idx;
      dcnt_r  <= 16'd0;
    end else if (upd_s) begin
      for (int i = 0; i < N; i++) cnt_r[i] <= step_cnt(cnt_r[i], sync_mm_s[i], counter_max);
      dcnt_r <= push_s ? 16'd0 : dcnt_r + 16'd1;
    end
  end

  assign fifo_empty = (count_r == {(AW+1){1'b0}});
  assign fifo_full  = (count_r == OCC_FULL);
  assign fifo_count = count_r;
  assign fifo_ovf   = ovf_r;
  assign pop_s      = fifo_rd_en && !fifo_empty;

  // Push into a full FIFO without a pop either drops or evicts the oldest entry
  always_comb begin
    wr_en_s   = push_s;
    rd_adv_s  = pop_s;
    ovf_set_s = 1'b0;
    if (push_s && fifo_full && !pop_s) begin
`ifdef SAMPLE_FIFO_OVERWRITE_EN
      rd_adv_s = 1'b1;
`else
      wr_en_s  = 1'b0;
`endif
      ovf_set_s = 1'b1;
    end else begin
      ovf_set_s = 1'b0;
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      ovf_r    <= 1'b0;
    end else begin
      if (wr_en_s)  wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (rd_adv_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({wr_en_s, rd_adv_s})
        2'b10:   count_r <= count_r + OCC_ONE;
        2'b01:   count_r <= count_r - OCC_ONE;
        default: count_r <= count_r;
      endcase
      if (start)          ovf_r <= 1'b0;
      else if (ovf_set_s) ovf_r <= 1'b1;
    end
  end

  // FIFO storage (contents survive reset; pointers define validity)
  always_ff @(posedge clk) begin
    if (wr_en_s && !rst) mem_r[wr_ptr_r] <= sync_mm_s;
  end

  // Show-ahead head and host counter read
  always_comb begin
    if (fifo_empty) fifo_rd_data = {N{1'b0}};
    else            fifo_rd_data = mem_r[rd_ptr_r];
    idx_s = (rd_addr - `PHASE_ADDR_BASE) >> 2;
    phase = {CW{1'b0}};
    for (int i = 0; i < N; i++) phase = phase | (cnt_r[i] & {CW{idx_s == 32'(i)}});
  end

endmodule

// File: tb/tb_phase_sample_fifo.sv
// Self-checking bench for phase_sample_fifo: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model.
`ifndef PHASE_ADDR_BASE
`define PHASE_ADDR_BASE 32'h0000_1000
`endif

module tb_phase_sample_fifo;
  localparam int N = 4, CW = 8, S = 3, DEPTH = 16;
  localparam logic [31:0] BASE = `PHASE_ADDR_BASE;
`ifdef SAMPLE_FIFO_OVERWRITE_EN
  localparam int HEAD_IDX = 4;
`else
  localparam int HEAD_IDX = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1, start = 1'b0, stop = 1'b0, fifo_rd_en = 1'b0;
  logic [CW-1:0] counter_max = '0, counter_cutoff = '0, phase;
  logic [1:0]    ref_idx = '0;
  logic [15:0]   decim = '0;
  logic [N-1:0]  outputs = '0, fifo_rd_data;
  logic [31:0]   rd_addr = '0;
  logic          fifo_empty, fifo_full, fifo_ovf, running;
  logic [4:0]    fifo_count;

  int errors = 0, checks = 0;

  int           m_cnt [N];
  logic [N-1:0] m_hist[$], m_q[$], m_log[$];
  bit           m_ovf, m_run;
  int           m_ref, m_dcnt;

  phase_sample_fifo #(.N(N), .CW(CW), .SYNC_STAGES(S), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .counter_max(counter_max),
    .counter_cutoff(counter_cutoff), .ref_idx(ref_idx), .decim(decim), .outputs(outputs),
    .rd_addr(rd_addr), .phase(phase), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_count(fifo_count),
    .fifo_ovf(fifo_ovf), .running(running));

  always #10 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock of the reference behaviour, evaluated on the inputs presented to this edge
  task automatic model_step();
    logic [N-1:0] mm, smm;
    bit pop, push;
    int lim;
    if (rst) begin
      m_hist.delete();
      for (int s = 0; s < S; s++) m_hist.push_back('0);
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_q.delete();
      m_ovf = 0; m_run = 0; m_ref = 0; m_dcnt = 0;
      return;
    end
    mm  = outputs[m_ref] ? ~outputs : outputs;
    smm = m_hist.pop_front();
    m_hist.push_back(mm);
    pop  = fifo_rd_en && (m_q.size() > 0);
    push = m_run && !start && !stop && (m_dcnt == int'(decim));
    if (start) begin
      lim = (int'(counter_cutoff) < int'(counter_max)) ? int'(counter_cutoff) : int'(counter_max);
      for (int i = 0; i < N; i++) m_cnt[i] = lim;
      m_dcnt = 0; m_ovf = 0; m_ref = int'(ref_idx); m_run = 1;
    end else if (m_run && stop) begin
      m_run = 0;
    end else if (m_run) begin
      for (int i = 0; i < N; i++) begin
        if (smm[i]) m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        else if (m_cnt[i] < int'(counter_max)) m_cnt[i] = m_cnt[i] + 1;
      end
      m_dcnt = push ? 0 : (m_dcnt + 1) % 65536;
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      m_log.push_back(smm);
      if (m_q.size() < DEPTH) m_q.push_back(smm);
      else begin
        m_ovf = 1;
`ifdef SAMPLE_FIFO_OVERWRITE_EN
        void'(m_q.pop_front());
        m_q.push_back(smm);
`endif
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    tick();
    tick();
    start = 1'b0; rst = 1'b0;
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", running); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", fifo_empty); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", fifo_full); end
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    checks++; if (fifo_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", fifo_ovf); end
    for (int i = 0; i < N; i++) begin
      rd_addr = BASE + 32'(4 * i); #1;
      checks++; if (phase !== 8'd0) begin errors++; $display("FAIL reset_phase[%0d]: got %0d want 0", i, phase); end
    end
  endtask

  task automatic test_in_phase();
    logic [CW-1:0] exp;
    counter_max = 8'd200; counter_cutoff = 8'd100; ref_idx = 2'd0; outputs = '0; decim = 16'hFFFF;
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL inphase_running: got %b want 1", running); end
    for (int k = 0; k <= 110; k++) begin
      exp = CW'((100 + k > 200) ? 200 : 100 + k);
      for (int i = 0; i < N; i++) begin
        rd_addr = BASE + 32'(4 * i); #1;
        checks++; if (phase !== exp) begin errors++; $display("FAIL inphase_cnt[%0d] k=%0d: got %0d want %0d", i, k, phase, exp); end
      end
      tick();
    end
  endtask

  task automatic test_mismatch();
    logic [CW-1:0] exp;
    stop = 1'b1; tick(); stop = 1'b0;
    outputs = 4'b0100; counter_cutoff = 8'd5;
    repeat (S + 1) tick();
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k <= 200; k++) begin
      for (int i = 0; i < N; i++) begin
        if (i == 2) exp = CW'((5 - k < 0) ? 0 : 5 - k);
        else        exp = CW'((5 + k > 200) ? 200 : 5 + k);
        rd_addr = BASE + 32'(4 * i); #1;
        checks++; if (phase !== exp) begin errors++; $display("FAIL mismatch_cnt[%0d] k=%0d: got %0d want %0d", i, k, phase, exp); end
      end
      tick();
    end
  endtask

  task automatic test_ref_switch();
    ref_idx = 2'd2; counter_cutoff = 8'd250;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < N; i++) begin
      rd_addr = BASE + 32'(4 * i); #1;
      checks++; if (phase !== 8'd200) begin errors++; $display("FAIL refsw_preload[%0d]: got %0d want 200", i, phase); end
    end
    repeat (300) tick();
    for (int i = 0; i < N; i++) begin
      rd_addr = BASE + 32'(4 * i); #1;
      checks++;
      if (phase !== ((i == 2) ? 8'd200 : 8'd0)) begin
        errors++; $display("FAIL refsw_final[%0d]: got %0d want %0d", i, phase, (i == 2) ? 200 : 0);
      end
    end
  endtask

  task automatic test_stop_freeze();
    logic [CW-1:0] exp;
    ref_idx = 2'd0; counter_cutoff = 8'd100;
    start = 1'b1; tick(); start = 1'b0;
    repeat (10) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    repeat (10) tick();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL stop_running: got %b want 0", running); end
    for (int i = 0; i < N; i++) begin
      exp = (i == 2) ? 8'd96 : 8'd104;
      rd_addr = BASE + 32'(4 * i); #1;
      checks++; if (phase !== exp) begin errors++; $display("FAIL stop_frozen[%0d]: got %0d want %0d", i, phase, exp); end
    end
  endtask

  task automatic test_decim();
    decim = 16'd3; m_log.delete();
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 40; k++) begin outputs = N'($urandom); tick(); end
    stop = 1'b1; tick(); stop = 1'b0;
    checks++; if (fifo_count !== 5'd10) begin errors++; $display("FAIL decim_count: got %0d want 10", fifo_count); end
    checks++; if (fifo_ovf !== 1'b0) begin errors++; $display("FAIL decim_ovf: got %b want 0", fifo_ovf); end
    for (int j = 0; j < 10; j++) begin
      checks++; if (fifo_rd_data !== m_log[j]) begin errors++; $display("FAIL decim_pop[%0d]: got %b want %b", j, fifo_rd_data, m_log[j]); end
      fifo_rd_en = 1'b1; tick(); fifo_rd_en = 1'b0;
    end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL decim_empty: got %b want 1", fifo_empty); end
    fifo_rd_en = 1'b1; tick(); fifo_rd_en = 1'b0;
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL decim_extra_pop_count: got %0d want 0", fifo_count); end
    checks++; if (fifo_rd_data !== 4'd0) begin errors++; $display("FAIL decim_empty_data: got %b want 0000", fifo_rd_data); end
  endtask

  task automatic test_overflow();
    decim = 16'd0; m_log.delete();
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 20; k++) begin outputs = N'($urandom); tick(); end
    checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL ovf_count: got %0d want 16", fifo_count); end
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", fifo_full); end
    checks++; if (fifo_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", fifo_ovf); end
    checks++; if (fifo_rd_data !== m_log[HEAD_IDX]) begin errors++; $display("FAIL ovf_head: got %b want %b", fifo_rd_data, m_log[HEAD_IDX]); end
    fifo_rd_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      outputs = N'($urandom); tick();
      checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL full_pushpop_count[%0d]: got %0d want 16", k, fifo_count); end
      checks++; if (fifo_ovf !== 1'b1) begin errors++; $display("FAIL full_pushpop_ovf[%0d]: got %b want 1", k, fifo_ovf); end
    end
    fifo_rd_en = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    checks++; if (fifo_rd_data !== m_q[0]) begin errors++; $display("FAIL ovf_head_after: got %b want %b", fifo_rd_data, m_q[0]); end
  endtask

  task automatic test_addr_oob();
    rd_addr = BASE + 32'(4 * N); #1;
    checks++; if (phase !== 8'd0) begin errors++; $display("FAIL addr_past_end: got %0d want 0", phase); end
    rd_addr = BASE - 32'd4; #1;
    checks++; if (phase !== 8'd0) begin errors++; $display("FAIL addr_below_base: got %0d want 0", phase); end
    rd_addr = BASE + 32'd4; #1;
    checks++; if (phase !== CW'(m_cnt[1])) begin errors++; $display("FAIL addr_in_range: got %0d want %0d", phase, m_cnt[1]); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst        = ($urandom_range(0, 99) == 0);
      start      = ($urandom_range(0, 24) == 0);
      stop       = ($urandom_range(0, 19) == 0);
      fifo_rd_en = ($urandom_range(0, 2) == 0);
      decim      = 16'($urandom_range(0, 3));
      outputs    = N'($urandom);
      ref_idx    = 2'($urandom);
      counter_cutoff = 8'($urandom);
      if ($urandom_range(0, 15) == 0) counter_max = 8'($urandom);
      tick();
      rst = 1'b0; start = 1'b0; stop = 1'b0; fifo_rd_en = 1'b0;
      checks++; if (running !== m_run) begin errors++; $display("FAIL rnd_running k=%0d: got %b want %b", k, running, m_run); end
      checks++; if (fifo_count !== 5'(m_q.size())) begin errors++; $display("FAIL rnd_count k=%0d: got %0d want %0d", k, fifo_count, m_q.size()); end
      checks++; if (fifo_empty !== (m_q.size() == 0)) begin errors++; $display("FAIL rnd_empty k=%0d: got %b", k, fifo_empty); end
      checks++; if (fifo_full !== (m_q.size() == DEPTH)) begin errors++; $display("FAIL rnd_full k=%0d: got %b", k, fifo_full); end
      checks++; if (fifo_ovf !== m_ovf) begin errors++; $display("FAIL rnd_ovf k=%0d: got %b want %b", k, fifo_ovf, m_ovf); end
      checks++;
      if (fifo_rd_data !== ((m_q.size() > 0) ? m_q[0] : 4'd0)) begin
        errors++; $display("FAIL rnd_head k=%0d: got %b want %b", k, fifo_rd_data, (m_q.size() > 0) ? m_q[0] : 4'd0);
      end
      for (int i = 0; i < N; i++) begin
        rd_addr = BASE + 32'(4 * i); #1;
        checks++; if (phase !== CW'(m_cnt[i])) begin errors++; $display("FAIL rnd_phase[%0d] k=%0d: got %0d want %0d", i, k, phase, m_cnt[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_in_phase();
    test_mismatch();
    test_ref_switch();
    test_stop_freeze();
    test_decim();
    test_overflow();
    test_addr_oob();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
